// File: rtl/stage_sequencer_pkg.sv
// stage_sequencer_pkg: stage encodings shared by the sequencer and its bench
package stage_sequencer_pkg;
  localparam int STAGE_W = 4;
  typedef enum logic [STAGE_W-1:0] {
    STAGE_INIT     = 4'd0,
    STAGE_IF       = 4'd1,
    STAGE_IF_WAIT  = 4'd2,
    STAGE_ID       = 4'd3,
    STAGE_EX       = 4'd4,
    STAGE_MEM      = 4'd5,
    STAGE_MEM_WAIT = 4'd6,
    STAGE_WB       = 4'd7,
    STAGE_HALT     = 4'd8
  } stage_e;
endpackage

// File: rtl/stage_wait_timer.sv
// stage_wait_timer: saturating wait counter with clear and per-use done limit
module stage_wait_timer #(
  parameter int WAIT_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic [WAIT_W-1:0] limit,
  output logic              done
);
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (&cnt_q ? cnt_q : cnt_q + 1'b1);
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
  assign done = cnt_q >= limit;
endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: multicycle stage controller with memory waits, halt/step and retire counter
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int IF_WAIT_CYC  = 1,
  parameter int MEM_WAIT_CYC = 1,
  parameter int WAIT_W       = 4,
  parameter int CNT_W        = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  input  logic               halt_req,
  input  logic               step_mode,
  input  logic               step_pulse,
  output logic               pc_wren,
  output logic               if_id_wren,
  output logic               id_ex_wren,
  output logic               ex_mem_wren,
  output logic               mem_wb_wren,
  output logic               ram_wren,
  output logic               reg_wren,
  output logic               stage_clear,
  output logic [STAGE_W-1:0] stage,
  output logic               halted,
  output logic               retire,
  output logic [CNT_W-1:0]   retired_count
);
  localparam logic [WAIT_W-1:0] IF_LIM  = WAIT_W'(IF_WAIT_CYC - 1);
  localparam logic [WAIT_W-1:0] MEM_LIM = WAIT_W'(MEM_WAIT_CYC - 1);
  stage_e stage_q, stage_d;
  logic [CNT_W-1:0] retired_count_q, retired_count_d;
  logic wait_done, if_done, mem_done;
  stage_wait_timer #(.WAIT_W(WAIT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (stage_q == STAGE_IF || stage_q == STAGE_MEM),
    .limit (stage_q == STAGE_MEM_WAIT ? MEM_LIM : IF_LIM),
    .done  (wait_done)
  );
  assign if_done  = stage_q == STAGE_IF_WAIT && wait_done && imem_ready;
  assign mem_done = stage_q == STAGE_MEM_WAIT && wait_done && dmem_ready;
  always_comb begin
    stage_d = stage_q;
    case (stage_q)
      STAGE_INIT:     stage_d = STAGE_IF;
      STAGE_IF:       stage_d = STAGE_IF_WAIT;
      STAGE_IF_WAIT:  stage_d = if_done ? STAGE_ID : STAGE_IF_WAIT;
      STAGE_ID:       stage_d = STAGE_EX;
      STAGE_EX:       stage_d = STAGE_MEM;
      STAGE_MEM:      stage_d = STAGE_MEM_WAIT;
      STAGE_MEM_WAIT: stage_d = mem_done ? STAGE_WB : STAGE_MEM_WAIT;
      STAGE_WB:       stage_d = (halt_req || step_mode) ? STAGE_HALT : STAGE_IF;
      STAGE_HALT:     stage_d = (!halt_req && (!step_mode || step_pulse)) ? STAGE_IF : STAGE_HALT;
      default:        stage_d = STAGE_INIT;
    endcase
    retired_count_d = retire ? retired_count_q + 1'b1 : retired_count_q;
  end
  always_ff @(posedge clk) begin
    stage_q         <= reset ? STAGE_INIT : stage_d;
    retired_count_q <= reset ? '0 : retired_count_d;
  end
  assign stage         = stage_q;
  assign if_id_wren    = if_done;
  assign id_ex_wren    = stage_q == STAGE_ID;
  assign ex_mem_wren   = stage_q == STAGE_EX;
  assign pc_wren       = stage_q == STAGE_MEM;
  assign ram_wren      = stage_q == STAGE_MEM;
  assign mem_wb_wren   = mem_done;
  assign reg_wren      = stage_q == STAGE_WB;
  assign retire        = stage_q == STAGE_WB;
  assign stage_clear   = stage_q == STAGE_WB || stage_q == STAGE_INIT;
  assign halted        = stage_q == STAGE_HALT;
  assign retired_count = retired_count_q;
endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: directed checks of the default sequencer and a long-wait, 4-bit-counter variant
module tb_stage_sequencer;
  logic clk = 0, reset = 1, imem_ready = 1, dmem_ready = 1;
  logic halt_req = 0, step_mode = 0, step_pulse = 0;
  logic pc_a, ifid_a, idex_a, exmem_a, memwb_a, ram_a, reg_a, clr_a, halted_a, retire_a;
  logic pc_b, ifid_b, idex_b, exmem_b, memwb_b, ram_b, reg_b, clr_b, halted_b, retire_b;
  logic [3:0] stage_a, stage_b;
  logic [31:0] count_a;
  logic [3:0] count_b;
  logic [9:0] en_a, en_b;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign en_a = {pc_a, ifid_a, idex_a, exmem_a, memwb_a, ram_a, reg_a, clr_a, halted_a, retire_a};
  assign en_b = {pc_b, ifid_b, idex_b, exmem_b, memwb_b, ram_b, reg_b, clr_b, halted_b, retire_b};
  stage_sequencer dut_a (
    .clk(clk), .reset(reset), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .halt_req(halt_req), .step_mode(step_mode), .step_pulse(step_pulse),
    .pc_wren(pc_a), .if_id_wren(ifid_a), .id_ex_wren(idex_a), .ex_mem_wren(exmem_a),
    .mem_wb_wren(memwb_a), .ram_wren(ram_a), .reg_wren(reg_a), .stage_clear(clr_a),
    .stage(stage_a), .halted(halted_a), .retire(retire_a), .retired_count(count_a)
  );
  stage_sequencer #(.IF_WAIT_CYC(3), .MEM_WAIT_CYC(2), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .halt_req(halt_req), .step_mode(step_mode), .step_pulse(step_pulse),
    .pc_wren(pc_b), .if_id_wren(ifid_b), .id_ex_wren(idex_b), .ex_mem_wren(exmem_b),
    .mem_wb_wren(memwb_b), .ram_wren(ram_b), .reg_wren(reg_b), .stage_clear(clr_b),
    .stage(stage_b), .halted(halted_b), .retire(retire_b), .retired_count(count_b)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic cyc_a(input string tag, input logic [3:0] st, input logic [9:0] en);
    tick();
    chk({tag, " stage_a"}, 32'(stage_a), 32'(st));
    chk({tag, " en_a"}, 32'(en_a), 32'(en));
  endtask
  task automatic cyc_b(input string tag, input logic [3:0] st, input logic [9:0] en);
    tick();
    chk({tag, " stage_b"}, 32'(stage_b), 32'(st));
    chk({tag, " en_b"}, 32'(en_b), 32'(en));
  endtask
  task automatic instr_a(input string tag);
    cyc_a({tag, " if"}, 4'd1, 10'h000);
    step_pulse = 0;
    cyc_a({tag, " ifw"}, 4'd2, 10'h100);
    cyc_a({tag, " id"}, 4'd3, 10'h080);
    cyc_a({tag, " ex"}, 4'd4, 10'h040);
    cyc_a({tag, " mem"}, 4'd5, 10'h210);
    cyc_a({tag, " mw"}, 4'd6, 10'h020);
    cyc_a({tag, " wb"}, 4'd7, 10'h00D);
  endtask
  task automatic instr_b(input string tag);
    cyc_b({tag, " if"}, 4'd1, 10'h000);
    cyc_b({tag, " ifw1"}, 4'd2, 10'h000);
    cyc_b({tag, " ifw2"}, 4'd2, 10'h000);
    cyc_b({tag, " ifw3"}, 4'd2, 10'h100);
    cyc_b({tag, " id"}, 4'd3, 10'h080);
    cyc_b({tag, " ex"}, 4'd4, 10'h040);
    cyc_b({tag, " mem"}, 4'd5, 10'h210);
    cyc_b({tag, " mw1"}, 4'd6, 10'h000);
    cyc_b({tag, " mw2"}, 4'd6, 10'h020);
    cyc_b({tag, " wb"}, 4'd7, 10'h00D);
  endtask
  initial begin
    tick();
    tick();
    chk("rst stage", 32'(stage_a), 32'd0);
    chk("rst en", 32'(en_a), 32'h004);
    chk("rst count", count_a, 32'd0);
    reset = 0;
    repeat (3) instr_a("norm");
    cyc_a("norm next", 4'd1, 10'h000);
    chk("norm count", count_a, 32'd3);
    reset = 1;
    tick();
    reset = 0;
    chk("rst_b stage", 32'(stage_b), 32'd0);
    chk("rst_b count", 32'(count_b), 32'd0);
    for (int i = 0; i < 16; i++) begin
      instr_b("long");
      chk("long count", 32'(count_b), 32'(i));
    end
    cyc_b("wrap next", 4'd1, 10'h000);
    chk("wrap count", 32'(count_b), 32'd0);
    reset = 1;
    dmem_ready = 0;
    tick();
    reset = 0;
    cyc_a("dw if", 4'd1, 10'h000);
    cyc_a("dw ifw", 4'd2, 10'h100);
    cyc_a("dw id", 4'd3, 10'h080);
    cyc_a("dw ex", 4'd4, 10'h040);
    cyc_a("dw mem", 4'd5, 10'h210);
    repeat (5) cyc_a("dw stall", 4'd6, 10'h000);
    dmem_ready = 1;
    #1;
    chk("dw ready stage", 32'(stage_a), 32'd6);
    chk("dw ready en", 32'(en_a), 32'h020);
    cyc_a("dw wb", 4'd7, 10'h00D);
    cyc_a("dw next", 4'd1, 10'h000);
    reset = 1;
    step_mode = 1;
    tick();
    reset = 0;
    instr_a("step1");
    cyc_a("halt1", 4'd8, 10'h002);
    chk("halt1 count", count_a, 32'd1);
    repeat (2) cyc_a("halt1 hold", 4'd8, 10'h002);
    step_pulse = 1;
    instr_a("step2");
    cyc_a("halt2", 4'd8, 10'h002);
    chk("halt2 count", count_a, 32'd2);
    halt_req = 1;
    step_pulse = 1;
    cyc_a("hreq pulse", 4'd8, 10'h002);
    step_pulse = 0;
    cyc_a("hreq hold", 4'd8, 10'h002);
    chk("hreq count", count_a, 32'd2);
    halt_req = 0;
    step_mode = 0;
    cyc_a("resume", 4'd1, 10'h000);
    reset = 1;
    tick();
    reset = 0;
    instr_a("pre");
    cyc_a("mid if", 4'd1, 10'h000);
    chk("mid count", count_a, 32'd1);
    cyc_a("mid ifw", 4'd2, 10'h100);
    cyc_a("mid id", 4'd3, 10'h080);
    cyc_a("mid ex", 4'd4, 10'h040);
    reset = 1;
    tick();
    chk("abort stage", 32'(stage_a), 32'd0);
    chk("abort en", 32'(en_a), 32'h004);
    chk("abort count", count_a, 32'd0);
    reset = 0;
    instr_a("after");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Parametrised successor to the fixed eight-step multicycle stage controller.
- Sequences one instruction at a time through IF, IF_WAIT, ID, EX, MEM, MEM_WAIT and WB, and drives the per-stage write enables.
- Adds configurable memory wait lengths, memory-ready handshakes, halt/single-step control and a retired-instruction counter.
- Sits at the top of the core beside the PC, pipeline latches, RAM and register file.

Parameters:
- IF_WAIT_CYC, 1, minimum cycles spent in IF_WAIT (must be >= 1).
- MEM_WAIT_CYC, 1, minimum cycles spent in MEM_WAIT (must be >= 1).
- WAIT_W, 4, wait counter width; must hold max(IF_WAIT_CYC, MEM_WAIT_CYC).
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- halt_req  in  1  request to stop after the current instruction
- step_mode  in  1  single-step mode enable
- step_pulse  in  1  one-cycle request to run one instruction while halted
- pc_wren  out  1  PC update enable
- if_id_wren  out  1  IF/ID latch enable
- id_ex_wren  out  1  ID/EX latch enable
- ex_mem_wren  out  1  EX/MEM latch enable
- mem_wb_wren  out  1  MEM/WB latch enable
- ram_wren  out  1  data RAM write strobe
- reg_wren  out  1  register file write enable
- stage_clear  out  1  active-high clear of stage latches
- stage  out  4  current state encoding
- halted  out  1  high while in HALT
- retire  out  1  one-cycle pulse per completed instruction
- retired_count  out  CNT_W  number of completed instructions

Behaviour:
- Reset:
  - Sampled on the clk rising edge, with priority over everything else.
  - Next state is INIT; the wait counter and retired_count are cleared to 0.
  - Reset asserted mid-instruction abandons that instruction; no enable fires on the next cycle.
- State register: stage; the outputs are a combinational (Moore) decode of stage, plus the wait-done terms listed below.
- Reset output values (state INIT): stage_clear=1; halted=0; retire=0; all wren outputs 0; retired_count=0.
- Transitions:
  - INIT -> IF.
  - IF -> IF_WAIT; wait counter loads 0.
  - IF_WAIT: counter increments each cycle.
    - if_done = (cnt >= IF_WAIT_CYC-1) && imem_ready.
    - if_done -> ID; otherwise stay in IF_WAIT.
    - Counter saturates at its maximum; it never wraps while waiting on ready.
  - ID -> EX.
  - EX -> MEM.
  - MEM -> MEM_WAIT; counter loads 0.
  - MEM_WAIT:
    - mem_done = (cnt >= MEM_WAIT_CYC-1) && dmem_ready.
    - mem_done -> WB; otherwise stay in MEM_WAIT.
  - WB -> HALT if (halt_req || step_mode); otherwise WB -> IF.
  - HALT:
    - halt_req=1: stay in HALT; step_pulse is ignored.
    - halt_req=0, step_mode=0: -> IF.
    - halt_req=0, step_mode=1, step_pulse=1: -> IF; exactly one instruction runs, then the block returns to HALT.
- Enable decode (all 0 unless listed):
  - IF_WAIT: if_id_wren = if_done; asserted only in the exit cycle, so it is a single pulse per instruction.
  - ID: id_ex_wren=1.
  - EX: ex_mem_wren=1.
  - MEM: pc_wren=1, ram_wren=1; exactly one cycle, regardless of wait length.
  - MEM_WAIT: mem_wb_wren = mem_done.
  - WB: reg_wren=1, stage_clear=1, retire=1.
  - HALT: halted=1.
- retired_count increments by 1 in each WB cycle and wraps from 2^CNT_W-1 to 0.
- halt_req, step_mode and step_pulse are sampled only in WB and HALT; their values in other states have no effect.
- Illegal stage encoding -> INIT on the next cycle.
- Minimum instruction latency: 7 cycles (IF through WB) with both waits at 1 and both ready inputs held high.

Decomposition:
- Shared package/include holds:
  - the stage encodings STAGE_INIT, STAGE_IF, STAGE_IF_WAIT, STAGE_ID, STAGE_EX, STAGE_MEM, STAGE_MEM_WAIT, STAGE_WB, STAGE_HALT (4-bit);
  - a stage-width constant.
- One sub-module, stage_wait_timer:
  - WAIT_W saturating up-counter;
  - load-zero input;
  - done output = cnt >= limit, where limit is supplied per use.

Test Plan:
- Defaults, imem_ready=dmem_ready=1, no halt:
  - reset released, then 7-cycle repeat IF..WB.
  - each enable pulses exactly once per 7 cycles.
  - retired_count reaches 3 after 21 cycles past INIT.
- IF_WAIT_CYC=3, MEM_WAIT_CYC=2:
  - period is 10 cycles.
  - if_id_wren is high only in the 3rd IF_WAIT cycle; mem_wb_wren only in the 2nd MEM_WAIT cycle.
- dmem_ready held low for 5 cycles in MEM_WAIT:
  - stage stays MEM_WAIT.
  - ram_wren and pc_wren fire once only.
  - mem_wb_wren fires the cycle ready returns.
- step_mode=1:
  - the block enters HALT after the first WB, with halted=1.
  - each step_pulse yields exactly one instruction (retire +1), then HALT again.
  - step_pulse while halt_req=1 does nothing.
- Reset asserted in EX mid-instruction:
  - next cycle stage=INIT, all wren=0, retired_count=0.
  - a normal sequence resumes after release.
- CNT_W=4:
  - after 16 instructions retired_count wraps to 0; retire still pulses.
